// File: rtl/tx_resp_scheduler.sv
// Response scheduler: queues ALU/RF results and feeds them
// byte-by-byte to the UART TX parallel interface.
module tx_resp_scheduler #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*DATA_W-1:0]   alu_out,
    input  logic                  alu_out_valid,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic                  rd_data_valid,
    input  logic                  tx_busy,
    input  logic                  ovf_clr,
    output logic [DATA_W-1:0]     tx_p_data,
    output logic                  tx_d_vld,
    output logic                  tx_active,
    output logic [PTR_W:0]        fifo_level,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam int EW = 2*DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t              state_q;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W:0]      wr_q, wr_d;
    logic [PTR_W:0]      rd_q, rd_d;
    logic [PTR_W:0]      level;
    logic [2*DATA_W-1:0] cur_q;
    logic [1:0]          left_q;
    logic [DATA_W-1:0]   tx_p_data_q;
    logic                tx_d_vld_q;
    logic                ovf_q, ovf_d;
    logic [7:0]          drop_q, drop_d;
    logic [EW-1:0]       head;
    logic                pop;
    logic [PTR_W+1:0]    free;
    logic                alu_keep;
    logic                rd_keep;
    logic [1:0]          n_drop;
    logic [8:0]          drop_sum;
    logic [PTR_W-1:0]    alu_idx;
    logic [PTR_W-1:0]    rd_idx;

    assign level = wr_q - rd_q;
    assign head  = mem_q[rd_q[PTR_W-1:0]];
    assign pop   = (state_q == IDLE) && (level != '0);

    // Space is judged after this cycle's pop; ALU claims a slot before RF.
    always_comb begin
        free     = (PTR_W+2)'(FIFO_DEPTH)
                 - (PTR_W+2)'(level)
                 + (PTR_W+2)'(pop);
        alu_keep = alu_out_valid && (free != '0);
        rd_keep  = rd_data_valid
                && (free > (PTR_W+2)'(alu_keep));
        alu_idx  = wr_q[PTR_W-1:0];
        rd_idx   = wr_q[PTR_W-1:0] + PTR_W'(alu_keep);
        wr_d     = wr_q + (PTR_W+1)'(alu_keep)
                        + (PTR_W+1)'(rd_keep);
        rd_d     = rd_q + (PTR_W+1)'(pop);
        n_drop   = 2'(alu_out_valid && !alu_keep)
                 + 2'(rd_data_valid && !rd_keep);
        drop_sum = {1'b0, drop_q} + 9'(n_drop);
        if (ovf_clr) begin
            ovf_d  = (n_drop != 2'd0);
            drop_d = 8'(n_drop);
        end else begin
            ovf_d  = ovf_q | (n_drop != 2'd0);
            drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (alu_keep) begin
            mem_q[alu_idx] <= {1'b1, alu_out};
        end
        if (rd_keep) begin
            mem_q[rd_idx] <= {1'b0, {DATA_W{1'b0}}, rd_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
            drop_q <= 8'd0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            left_q      <= 2'd0;
            tx_p_data_q <= '0;
            tx_d_vld_q  <= 1'b0;
        end else begin
            tx_d_vld_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        cur_q   <= head[2*DATA_W-1:0];
                        left_q  <= head[EW-1] ? 2'd2 : 2'd1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_p_data_q <= cur_q[DATA_W-1:0];
                        tx_d_vld_q  <= 1'b1;
                        state_q     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (left_q == 2'd2) begin
                            cur_q   <= cur_q >> DATA_W;
                            left_q  <= 2'd1;
                            state_q <= SEND;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_p_data  = tx_p_data_q;
    assign tx_d_vld   = tx_d_vld_q;
    assign tx_active  = (state_q != IDLE);
    assign fifo_level = level;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_tx_resp_scheduler.sv
// Bench for tx_resp_scheduler: transaction-level model, per-cycle
// output compare, UART busy responder and directed/random stimulus.
module tb_tx_resp_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_out_valid = 1'b0;
    logic [7:0]  rd_data = '0;
    logic        rd_data_valid = 1'b0;
    logic        tx_busy;
    logic        ovf_clr = 1'b0;
    logic [7:0]  tx_p_data;
    logic        tx_d_vld;
    logic        tx_active;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    tx_resp_scheduler #(.DATA_W(8), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .tx_busy       (tx_busy),
        .ovf_clr       (ovf_clr),
        .tx_p_data     (tx_p_data),
        .tx_d_vld      (tx_d_vld),
        .tx_active     (tx_active),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fv_cyc = 0;
    int scyc = 0;
    int peak = 0;

    // UART TX responder: 10-cycle frame after each accepted byte
    int   ucnt = 0;
    logic force_busy = 1'b0;
    assign tx_busy = force_busy | (ucnt != 0);

    always @(negedge clk) begin
        if (tx_d_vld) ucnt = 10;
        else if (ucnt > 0) ucnt--;
    end

    // Transaction model: queue of entries plus the bytes of the entry in service
    logic [16:0] mq[$];
    logic [7:0]  pend[$];
    logic [7:0]  msent[$];
    logic [7:0]  got[$];
    logic [7:0]  ex[$];
    bit          eng, w_rise, w_fall, ak, rk;
    logic        e_vld, e_ovf;
    logic [7:0]  e_data, e_drop;
    logic [16:0] ent;
    int          free, drops, sum;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            pend.delete();
            eng = 0; w_rise = 0; w_fall = 0;
            e_vld = 0; e_data = 0; e_ovf = 0; e_drop = 0;
        end else begin
            e_vld = 0;
            if (!eng) begin
                if (mq.size() > 0) begin
                    ent = mq.pop_front();
                    pend.delete();
                    pend.push_back(ent[7:0]);
                    if (ent[16]) pend.push_back(ent[15:8]);
                    eng = 1;
                end
            end else if (w_rise) begin
                if (tx_busy) begin w_rise = 0; w_fall = 1; end
            end else if (w_fall) begin
                if (!tx_busy) begin
                    w_fall = 0;
                    if (pend.size() == 0) eng = 0;
                end
            end else if (!tx_busy) begin
                e_vld = 1;
                e_data = pend.pop_front();
                msent.push_back(e_data);
                w_rise = 1;
            end
            free = 4 - mq.size();
            ak = alu_out_valid && (free >= 1);
            rk = rd_data_valid && (free >= 1 + int'(ak));
            if (ak) mq.push_back({1'b1, alu_out});
            if (rk) mq.push_back({9'd0, rd_data});
            drops = int'(alu_out_valid && !ak) + int'(rd_data_valid && !rk);
            if (ovf_clr) begin
                e_ovf = (drops != 0);
                e_drop = 8'(drops);
            end else begin
                e_ovf = e_ovf | (drops != 0);
                sum = int'(e_drop) + drops;
                e_drop = (sum > 255) ? 8'd255 : 8'(sum);
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        n_cmp++;
        if (tx_d_vld !== e_vld || tx_p_data !== e_data ||
            tx_active !== eng || fifo_level !== 3'(mq.size()) ||
            overflow !== e_ovf || drop_cnt !== e_drop) begin
            n_bad++;
            $display("FAIL cycle%0d outputs: got vld=%0b d=%h act=%0b lvl=%0d ovf=%0b drop=%0d want vld=%0b d=%h act=%0b lvl=%0d ovf=%0b drop=%0d",
                     cyc, tx_d_vld, tx_p_data, tx_active, fifo_level,
                     overflow, drop_cnt, e_vld, e_data, eng, mq.size(),
                     e_ovf, e_drop);
        end
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        if (tx_d_vld) begin
            if (got.size() == 0) fv_cyc = cyc;
            got.push_back(tx_p_data);
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic chk_bytes(input string name);
        n_cmp++;
        if (got.size() != ex.size() || msent.size() != ex.size()) begin
            n_bad++;
            $display("FAIL %s count: dut %0d model %0d want %0d",
                     name, got.size(), msent.size(), ex.size());
        end else begin
            foreach (ex[i]) begin
                if (got[i] !== ex[i] || msent[i] !== ex[i]) begin
                    n_bad++;
                    $display("FAIL %s byte%0d: dut %h model %h want %h",
                             name, i, got[i], msent[i], ex[i]);
                    break;
                end
            end
        end
    endtask

    task automatic clr_log();
        got.delete();
        msent.delete();
    endtask

    task automatic strobe(input bit av, input logic [15:0] a,
                          input bit rv, input logic [7:0] r);
        alu_out_valid = av; alu_out = a;
        rd_data_valid = rv; rd_data = r;
        @(negedge clk);
        alu_out_valid = 0; rd_data_valid = 0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (mq.size() == 0 && !eng && !tx_busy) begin
                done = 1;
                break;
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL drain timeout: got busy want idle");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        ovf_clr = 1;
        @(negedge clk);
        ovf_clr = 0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset vld", int'(tx_d_vld), 0);
        check("reset data", int'(tx_p_data), 0);
        check("reset level", int'(fifo_level), 0);
        rst = 1;
        repeat (2) @(negedge clk);

        // 1: single ALU result, latency and byte order
        clr_log();
        scyc = cyc;
        strobe(1, 16'hA55A, 0, 8'h00);
        drain();
        ex = {8'h5A, 8'hA5};
        chk_bytes("t1 bytes");
        check("t1 latency", fv_cyc - scyc, 3);
        check("t1 active", int'(tx_active), 0);

        // 2: ALU and RF in the same cycle
        clr_log();
        peak = 0;
        strobe(1, 16'h1234, 1, 8'h77);
        drain();
        ex = {8'h34, 8'h12, 8'h77};
        chk_bytes("t2 bytes");
        check("t2 peak level", peak, 2);

        // 3: overflow with UART held busy
        clr_log();
        force_busy = 1;
        strobe(0, 0, 1, 8'h00);
        for (int i = 1; i <= 6; i++) strobe(0, 0, 1, 8'(i));
        @(negedge clk);
        check("t3 level", int'(fifo_level), 4);
        check("t3 overflow", int'(overflow), 1);
        check("t3 drop_cnt", int'(drop_cnt), 2);
        force_busy = 0;
        drain();
        ex = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        chk_bytes("t3 bytes");
        pulse_clr();
        check("t3 clr overflow", int'(overflow), 0);
        check("t3 clr drop_cnt", int'(drop_cnt), 0);

        // 4: three queued, ALU+RF together with no pop
        clr_log();
        force_busy = 1;
        strobe(0, 0, 1, 8'h10);
        strobe(0, 0, 1, 8'h11);
        strobe(0, 0, 1, 8'h12);
        strobe(0, 0, 1, 8'h13);
        strobe(1, 16'hC0DE, 1, 8'h14);
        check("t4 level", int'(fifo_level), 4);
        check("t4 drop_cnt", int'(drop_cnt), 1);
        force_busy = 0;
        drain();
        ex = {8'h10, 8'h11, 8'h12, 8'h13, 8'hDE, 8'hC0};
        chk_bytes("t4 bytes");
        pulse_clr();

        // 5: reset between the two bytes of an ALU result
        clr_log();
        strobe(1, 16'hBEEF, 0, 8'h00);
        for (int i = 0; i < 50 && got.size() == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("t5 rst data", int'(tx_p_data), 0);
        check("t5 rst active", int'(tx_active), 0);
        check("t5 rst level", int'(fifo_level), 0);
        rst = 1;
        drain();
        repeat (10) @(negedge clk);
        ex = {8'hEF};
        chk_bytes("t5 bytes");

        // 6: pointer wrap with drains
        clr_log();
        ex.delete();
        for (int i = 0; i < 10; i++) begin
            strobe(0, 0, 1, 8'(8'h20 + i));
            ex.push_back(8'(8'h20 + i));
            drain();
        end
        chk_bytes("t6 bytes");
        check("t6 overflow", int'(overflow), 0);

        // random traffic with foreign busy and occasional clears
        clr_log();
        for (int i = 0; i < 600; i++) begin
            alu_out_valid = ($urandom_range(0, 3) == 0);
            alu_out = 16'($urandom);
            rd_data_valid = ($urandom_range(0, 2) == 0);
            rd_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 40) == 0);
            force_busy = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        alu_out_valid = 0; rd_data_valid = 0;
        ovf_clr = 0; force_busy = 0;
        drain();
        ex = msent;
        chk_bytes("random stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
